// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : wide_add_seq
// Brief    : Multi-word adder that reuses one 32-bit carry-select adder over
//            NWORDS cycles, least significant word first, and reports sum,
//            unsigned carry-out and two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================

// 32-bit carry-select adder: the upper half is precomputed for both carry
// values and picked by the carry out of the lower half.
module csa_32bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout
);
    logic [16:0] w_lo;
    logic [16:0] w_hi0;
    logic [16:0] w_hi1;

    assign w_lo   = {1'b0, i_a[15:0]} + {1'b0, i_b[15:0]} + {16'd0, i_cin};
    assign w_hi0  = {1'b0, i_a[31:16]} + {1'b0, i_b[31:16]};
    assign w_hi1  = w_hi0 + 17'd1;
    assign o_sum  = {(w_lo[16] ? w_hi1[15:0] : w_hi0[15:0]), w_lo[15:0]};
    assign o_cout = w_lo[16] ? w_hi1[16] : w_hi0[16];
endmodule

module wide_add_seq #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [32*NWORDS-1:0]   a,
    input  logic [32*NWORDS-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [32*NWORDS-1:0]   sum,
    output logic                   cout,
    output logic                   overflow
);
    localparam int c_kw = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [c_kw-1:0] c_last = c_kw'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    logic [NWORDS-1:0][31:0]     r_a;
    logic [NWORDS-1:0][31:0]     r_b;
    logic [NWORDS-1:0][31:0]     r_part;
    logic [c_kw-1:0]             r_k;
    logic                        r_carry;
    logic                        r_busy;
    logic                        r_done;
    logic [32*NWORDS-1:0]        r_sum;
    logic                        r_cout;
    logic                        r_ovf;

    logic [31:0]                 w_sum;
    logic                        w_cout;
    logic [NWORDS-1:0][31:0]     w_next_part;
    logic                        w_ovf;

    csa_32bit u_csa (
        .i_a    (r_a[r_k]),
        .i_b    (r_b[r_k]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Partial result with the current word merged in; on the last word this
    // is the complete result.
    always_comb begin
        w_next_part      = r_part;
        w_next_part[r_k] = w_sum;
    end

    // Signed overflow: operands agree in sign but the result's sign differs.
    assign w_ovf = (r_a[NWORDS-1][31] == r_b[NWORDS-1][31]) &&
                   (w_sum[31] != r_a[NWORDS-1][31]);

    // Control FSM plus datapath registers; results only move on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_part  <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_part  <= w_next_part;
                    r_carry <= w_cout;
                    if (r_k == c_last) begin
                        r_k     <= '0;
                        r_sum   <= w_next_part;
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_ovf;
endmodule
`default_nettype wire

// File: doc/wide_add_seq.md
WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4: number of 32-bit words per operand, legal range 2..8.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition, sampled on a rising edge.
REQ-005 SHALL have port a  input  32*NWORDS  operand A, captured when start is accepted.
REQ-006 SHALL have port b  input  32*NWORDS  operand B, captured when start is accepted.
REQ-007 SHALL have port cin  input  1  carry-in to word 0, captured when start is accepted.
REQ-008 SHALL have port busy  output  1  high while words are being added.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new valid result.
REQ-010 SHALL have port sum  output  32*NWORDS  registered result.
REQ-011 SHALL have port cout  output  1  carry-out of the top word.
REQ-012 SHALL have port overflow  output  1  two's-complement signed overflow of the full-width add.

Function
REQ-013 SHALL instantiate one csa_32bit and reuse it over NWORDS cycles, least significant word first.
REQ-014 SHALL implement three states:
- IDLE: busy=0, done=0.
- RUN: busy=1, done=0.
- DONE: busy=0, done=1.
REQ-015 In IDLE, start=1 SHALL capture a, b and cin into operand registers, set word index k=0, set carry register=cin, and go to RUN.
REQ-016 In RUN, each edge SHALL:
- drive the adder with word k of A, word k of B, and the carry register;
- write the 32-bit adder sum into word k of the partial-result register;
- load the carry register with the adder cout;
- increment k.
REQ-017 On the edge that processes word NWORDS-1, SHALL:
- copy the completed partial result (including that final word) into sum;
- set cout to that edge's adder carry-out;
- set overflow to (A[msb]==B[msb]) && (result[msb]!=A[msb]);
- go to DONE.
REQ-018 Latency: with start accepted on edge E0, done SHALL be high for exactly the one cycle following edge E(NWORDS).
REQ-019 sum, cout and overflow SHALL hold their previous values throughout RUN and change only on the edge entering DONE; they SHALL remain stable until the next completion.
REQ-020 start while in RUN SHALL be ignored: no recapture, no effect on the operation in progress.
REQ-021 From DONE, start=1 SHALL be accepted as in IDLE and go directly to RUN (back-to-back operation); with start=0, DONE SHALL go to IDLE.
REQ-022 Arithmetic SHALL be modulo 2^(32*NWORDS); cout is the unsigned carry-out; no saturation.
REQ-023 Changes on a, b or cin after capture SHALL NOT affect the operation in progress.

Reset
REQ-024 rst=1 SHALL asynchronously force:
- state=IDLE, k=0;
- carry, operand and partial-result registers to 0;
- busy=0, done=0, sum=0, cout=0, overflow=0.
REQ-025 rst asserted during RUN SHALL abort the operation, discard the partial result, and produce no done pulse.
REQ-026 After rst deasserts, the first accepted start SHALL behave per REQ-015.

Verification (NWORDS=4)
REQ-027 a=all ones (128 bits), b=1, cin=0, start pulse -> done one cycle after the 4th edge after the start edge; sum=0, cout=1, overflow=0; busy high for exactly 4 cycles.
REQ-028 a=0x7FFF_..._FFFF, b=1, cin=0 -> sum=0x8000_0000_..._0000, cout=0, overflow=1.
REQ-029 a=0, b=0, cin=1 -> sum=1, cout=0, overflow=0; a=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, b=1 -> sum=0x0000_0001_0000_0000_0000_0000_0000_0000 (carry ripples through words 0-2).
REQ-030 start held high continuously, with a and b changed during RUN -> only the values captured at the accepting edge are used; a new operation is accepted in the DONE cycle and its done follows 4 edges later.
REQ-031 rst pulsed on the 2nd RUN edge of an operation that would give sum=5 -> busy=0, done never pulses, sum=0; a subsequent start with a=2, b=3 -> sum=5 on done.
